alu_issue: RTL and testbench

Command sequencer that drives the ALU from the controller side. It accepts one instruction per valid/ready handshake and reads the two source operands from an 8 × 16-bit register file. It presents opcode, A, B and shift to the combinational ALU, captures Y, and writes the result back. It sits between the receiver control logic and the ALU and owns the operand register file.

---
 rtl/alu_issue.sv | 117 +++++++++++
 tb/tb_alu_issue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Command sequencer driving a combinational ALU; owns an 8 x 16-bit register file.
// Optional macro ALU_ISSUE_FWD_EN: accept in WB with write-back forwarding (2-cycle throughput).
module alu_issue #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_N  = 8,
    parameter int unsigned OP_W   = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [OP_W-1:0]           cmd_op,
    input  logic [$clog2(REG_N)-1:0]  cmd_dst,
    input  logic [$clog2(REG_N)-1:0]  cmd_srca,
    input  logic [$clog2(REG_N)-1:0]  cmd_srcb,
    input  logic [4:0]                cmd_shift,
    input  logic [DATA_W-1:0]         cmd_imm,
    output logic [OP_W-1:0]           alu_opcode,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [4:0]                alu_shift,
    input  logic [DATA_W-1:0]         alu_y,
    output logic                      wb_valid,
    output logic [$clog2(REG_N)-1:0]  wb_dst,
    output logic [DATA_W-1:0]         wb_data,
    input  logic [$clog2(REG_N)-1:0]  rd_addr,
    output logic [DATA_W-1:0]         rd_data
);
    localparam int unsigned ADDR_W = $clog2(REG_N);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t              state;
    logic [DATA_W-1:0]   rf [REG_N];
    logic [ADDR_W-1:0]   dst_q;
    logic [DATA_W-1:0]   imm_q;
    logic                ldi_q;
    logic                hs;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;

    assign hs      = cmd_valid && cmd_ready;
    assign rd_data = rf[rd_addr];

    // Source operand select; forwarding only matters for an acceptance during WB.
    always_comb begin
        op_a = rf[cmd_srca];
        op_b = rf[cmd_srcb];
`ifdef ALU_ISSUE_FWD_EN
        if (state == WB && cmd_srca == wb_dst) op_a = wb_data;
        if (state == WB && cmd_srcb == wb_dst) op_b = wb_data;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_shift  <= '0;
            wb_valid   <= 1'b0;
            wb_dst     <= '0;
            wb_data    <= '0;
            dst_q      <= '0;
            imm_q      <= '0;
            ldi_q      <= 1'b0;
            for (int unsigned i = 0; i < REG_N; i++) rf[i] <= '0;
        end else begin
            // ALU operands change only on acceptance and hold otherwise.
            if (hs) begin
                alu_opcode <= cmd_op;
                alu_a      <= op_a;
                alu_b      <= op_b;
                alu_shift  <= cmd_shift;
                dst_q      <= cmd_dst;
                imm_q      <= cmd_imm;
                ldi_q      <= (cmd_op == OP_W'(0));
            end
            case (state)
                IDLE: begin
                    if (hs) begin
                        state     <= EXEC;
                        cmd_ready <= 1'b0;
                    end
                end
                EXEC: begin
                    state    <= WB;
                    wb_valid <= 1'b1;
                    wb_dst   <= dst_q;
                    wb_data  <= ldi_q ? imm_q : alu_y;
`ifdef ALU_ISSUE_FWD_EN
                    cmd_ready <= 1'b1;
`else
                    cmd_ready <= 1'b0;
`endif
                end
                WB: begin
                    wb_valid    <= 1'b0;
                    rf[wb_dst]  <= wb_data;
                    if (hs) begin
                        state     <= EXEC;
                        cmd_ready <= 1'b0;
                    end else begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: random and directed commands against a sequential ISA model.
`timescale 1ns/1ps
module tb_alu_issue;
`ifdef ALU_ISSUE_FWD_EN
    localparam int  STEP = 2;
    localparam bit  FWD  = 1'b1;
`else
    localparam int  STEP = 3;
    localparam bit  FWD  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_op = '0;
    logic [2:0]  cmd_dst = '0, cmd_srca = '0, cmd_srcb = '0;
    logic [4:0]  cmd_shift = '0;
    logic [15:0] cmd_imm = '0;
    logic [5:0]  alu_opcode;
    logic [15:0] alu_a, alu_b, alu_y;
    logic [4:0]  alu_shift;
    logic        wb_valid;
    logic [2:0]  wb_dst;
    logic [15:0] wb_data;
    logic [2:0]  rd_addr = '0;
    logic [15:0] rd_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = -100;

    typedef struct {
        logic [2:0]  dst;
        logic [15:0] data;
        logic [15:0] a;
        logic [15:0] b;
        int          cyc;
    } exp_t;
    exp_t q[$];
    logic [15:0] mrf [8];

    alu_issue dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
        .cmd_shift(cmd_shift), .cmd_imm(cmd_imm), .alu_opcode(alu_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shift(alu_shift), .alu_y(alu_y),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in ALU: op1 = (A<<sh)+B, op2 = A^B, op3 = A-B, else A&B.
    function automatic logic [15:0] alu_f(input logic [5:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [4:0] sh);
        case (op)
            6'd1:    return 16'(a << sh) + b;
            6'd2:    return a ^ b;
            6'd3:    return a - b;
            default: return a & b;
        endcase
    endfunction
    assign alu_y = alu_f(alu_opcode, alu_a, alu_b, alu_shift);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare every write-back, and police cmd_ready in EXEC/WB.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_wb", 32'(wb_dst), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wb_dst", 32'(wb_dst), 32'(e.dst));
                    chk("wb_data", 32'(wb_data), 32'(e.data));
                    chk("alu_a", 32'(alu_a), 32'(e.a));
                    chk("alu_b", 32'(alu_b), 32'(e.b));
                    chk("wb_latency", 32'(cyc), 32'(e.cyc));
                end
            end
            if (cyc == last_acc) chk("ready_exec", 32'(cmd_ready), 32'd0);
            if (cyc == last_acc + 1) chk("ready_wb", 32'(cmd_ready), 32'(FWD));
        end
    end

    task automatic issue(input logic [5:0] op, input logic [2:0] d, input logic [2:0] a,
                         input logic [2:0] b, input logic [4:0] sh, input logic [15:0] imm,
                         output int acc);
        exp_t e;
        cmd_op = op; cmd_dst = d; cmd_srca = a; cmd_srcb = b; cmd_shift = sh; cmd_imm = imm;
        cmd_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                e.dst  = d;
                e.a    = mrf[a];
                e.b    = mrf[b];
                e.data = (op == 6'd0) ? imm : alu_f(op, mrf[a], mrf[b], sh);
                e.cyc  = cyc + 2;
                q.push_back(e);
                mrf[d] = e.data;
                acc = cyc + 1;
                @(posedge clk);
                #1;
                last_acc = acc;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string name);
        for (int r = 0; r < 8; r++) begin
            rd_addr = 3'(r);
            #1;
            chk(name, {13'd0, 3'(r), rd_data}, {13'd0, 3'(r), mrf[r]});
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_alu", {alu_opcode, alu_shift, wb_dst}, 32'd0);
        chk("rst_ab", {alu_a, alu_b}, 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
    endtask

    initial begin
        int a1, a2, acc;
        int accs[4];
        for (int r = 0; r < 8; r++) mrf[r] = '0;

        repeat (2) @(negedge clk);
        check_reset_outputs();
        check_rf("rst_rf");
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset while an LDI sits in EXEC: nothing may be written.
        issue(6'd0, 3'd1, 3'd0, 3'd0, 5'd0, 16'h0003, acc);
        rst = 1'b1;
        q.delete();
        last_acc = -100;
        for (int r = 0; r < 8; r++) mrf[r] = '0;
        #1;
        check_reset_outputs();
        rd_addr = 3'd1; #1;
        chk("rst_mid_r1", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_no_wb", 32'(wb_valid), 32'd0);
        check_rf("post_rst_rf");

        // LDI r1, r2 then ADD shift sweep.
        issue(6'd0, 3'd1, 3'd0, 3'd0, 5'd0, 16'h0001, acc);
        issue(6'd0, 3'd2, 3'd0, 3'd0, 5'd0, 16'h0001, acc);
        drain();
        rd_addr = 3'd1; #1; chk("r1_ldi", 32'(rd_data), 32'h0001);
        rd_addr = 3'd2; #1; chk("r2_ldi", 32'(rd_data), 32'h0001);
        for (int s = 0; s < 15; s++) begin
            issue(6'd1, 3'd3, 3'd1, 3'd2, 5'(s), 16'h0, acc);
            drain();
            rd_addr = 3'd3; #1;
            chk("sweep_r3", 32'(rd_data), 32'((17'd1 << s) + 17'd1));
        end

        // Truncation: (8001<<15)+8001 in 16 bits.
        issue(6'd0, 3'd4, 3'd0, 3'd0, 5'd0, 16'h8001, acc);
        issue(6'd1, 3'd4, 3'd4, 3'd4, 5'd15, 16'h0, acc);
        drain();
        rd_addr = 3'd4; #1; chk("trunc_r4", 32'(rd_data), 32'h0001);

        // Back-to-back with continuous valid: acceptance spacing.
        for (int i = 0; i < 4; i++) begin
            issue(6'd2, 3'(i), 3'(i + 1), 3'(i + 2), 5'd0, 16'h0, accs[i]);
        end
        for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(accs[i] - accs[i-1]), 32'(STEP));
        drain();

        // Dependent pair: r6 = r5 + r5 right after LDI r5.
        issue(6'd0, 3'd5, 3'd0, 3'd0, 5'd0, 16'h00AA, a1);
        issue(6'd1, 3'd6, 3'd5, 3'd5, 5'd0, 16'h0, a2);
        chk("dep_spacing", 32'(a2 - a1), 32'(STEP));
        drain();
        rd_addr = 3'd6; #1; chk("dep_r6", 32'(rd_data), 32'h0154);

        // Random traffic with random gaps.
        for (int i = 0; i < 60; i++) begin
            logic [5:0] op;
            op = 6'($urandom_range(0, 3));
            issue(op, 3'($urandom), 3'($urandom), 3'($urandom), 5'($urandom), 16'($urandom), acc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        check_rf("final_rf");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
